// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : fpu_pkg
// Purpose : Constants and types shared by the FPU datapath and the exception
//           collector. It holds the exception bit positions, the "no trap"
//           code, the collector state encoding and the exponent/sign field
//           widths derived from the result width.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fpu_pkg;

  // Bit positions in the 5-bit exception vector
  localparam int EXC_INEXACT   = 0;
  localparam int EXC_INVALID   = 1;
  localparam int EXC_DIV0      = 2;
  localparam int EXC_UNDERFLOW = 3;
  localparam int EXC_OVERFLOW  = 4;
  localparam int EXC_WIDTH     = 5;

  localparam logic [2:0] TRAP_CODE_NONE = 3'd7;

  // Collector state encoding
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    TRAP   = 2'd1,
    RESUME = 2'd2
  } coll_state_e;

  // IEEE-754 field widths derived from the result width
  localparam int SGN_WIDTH = 1;

  function automatic int exp_width(input int bit_width);
    case (bit_width)
      16:      return 5;
      64:      return 11;
      128:     return 15;
      default: return 8;
    endcase
  endfunction

  function automatic int man_width(input int bit_width);
    return bit_width - exp_width(bit_width) - SGN_WIDTH;
  endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_exc_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : fpu_exc_prio_enc
// Purpose : Combinational priority encoder. It turns an exception cause
//           vector into a trap code. Priority, highest first: invalid, div0,
//           overflow, underflow, inexact. An empty cause gives TRAP_CODE_NONE.
// Ports   : i_cause [4:0]  enabled exception cause vector
//           o_code  [2:0]  bit index of the winning cause, 3'd7 if none
// Rev     : 1.0  initial release
// ============================================================================
module fpu_exc_prio_enc
  import fpu_pkg::*;
(
  input  logic [EXC_WIDTH-1:0] i_cause,
  output logic [2:0]           o_code
);

  // The checks run from lowest to highest priority. The last match wins.
  always_comb begin
    o_code = TRAP_CODE_NONE;
    if (i_cause[EXC_INEXACT])   o_code = 3'(EXC_INEXACT);
    if (i_cause[EXC_UNDERFLOW]) o_code = 3'(EXC_UNDERFLOW);
    if (i_cause[EXC_OVERFLOW])  o_code = 3'(EXC_OVERFLOW);
    if (i_cause[EXC_DIV0])      o_code = 3'(EXC_DIV0);
    if (i_cause[EXC_INVALID])   o_code = 3'(EXC_INVALID);
  end

endmodule : fpu_exc_prio_enc
`default_nettype wire

// File: rtl/fpu_exception_collector.sv
`default_nettype none
// ============================================================================
// Module  : fpu_exception_collector
// Purpose : Receives FPU result beats with their exception vectors. It keeps
//           sticky flags and a saturating exception-event counter. It raises
//           a trap request when an enabled exception is accepted, and holds
//           off further beats until the sequencer acknowledges the trap.
// Ports   : clk, rst_n (async, active-low)
//           i_valid/o_ready           beat handshake
//           i_result, i_exception     beat payload
//           i_trap_en                 per-flag trap enable mask
//           i_clear                   clear sticky flags and counter
//           i_trap_ack                trap acknowledge from sequencer
//           o_sticky, o_exc_count     accumulated status
//           o_trap_req, o_trap_cause, o_trap_code, o_trap_result  trap info
// Rev     : 1.0  initial release
// ============================================================================
module fpu_exception_collector
  import fpu_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [BIT_WIDTH-1:0]   i_result,
  input  logic [EXC_WIDTH-1:0]   i_exception,
  input  logic [EXC_WIDTH-1:0]   i_trap_en,
  input  logic                   i_clear,
  input  logic                   i_trap_ack,
  output logic [EXC_WIDTH-1:0]   o_sticky,
  output logic [COUNT_WIDTH-1:0] o_exc_count,
  output logic                   o_trap_req,
  output logic [EXC_WIDTH-1:0]   o_trap_cause,
  output logic [2:0]             o_trap_code,
  output logic [BIT_WIDTH-1:0]   o_trap_result
);

  localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX = '1;

  coll_state_e              r_state;
  coll_state_e              w_state_nxt;
  logic [EXC_WIDTH-1:0]     r_sticky;
  logic [EXC_WIDTH-1:0]     w_sticky_nxt;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [COUNT_WIDTH-1:0]   w_count_nxt;
  logic [EXC_WIDTH-1:0]     r_trap_cause;
  logic [2:0]               r_trap_code;
  logic [BIT_WIDTH-1:0]     r_trap_result;

  logic                     w_accept;
  logic                     w_trap_hit;
  logic [EXC_WIDTH-1:0]     w_cause;
  logic [2:0]               w_code;

  // Gating with rst_n keeps o_ready low while reset is held.
  assign o_ready    = (r_state == RUN) && rst_n;
  assign w_accept   = i_valid && o_ready;
  assign w_cause    = i_exception & i_trap_en;
  assign w_trap_hit = w_accept && (|w_cause);

  fpu_exc_prio_enc u_prio_enc (
    .i_cause (w_cause),
    .o_code  (w_code)
  );

  // Next-state logic. o_ready follows r_state, so the handshake needs no
  // extra outputs from this process.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_trap_hit) w_state_nxt = TRAP;
      TRAP:    if (i_trap_ack) w_state_nxt = RESUME;
      RESUME:  w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // Clear is applied first, then the accepted beat is folded in. A beat that
  // arrives together with a clear therefore starts a new accumulation.
  always_comb begin
    w_sticky_nxt = i_clear ? '0 : r_sticky;
    w_count_nxt  = i_clear ? '0 : r_count;
    if (w_accept) begin
      w_sticky_nxt = w_sticky_nxt | i_exception;
      if ((|i_exception) && (w_count_nxt != C_CNT_MAX))
        w_count_nxt = w_count_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= '0;
      r_count  <= '0;
    end else begin
      r_sticky <= w_sticky_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // The trap registers change only when a new trap is latched. They keep
  // their values through TRAP, RESUME and RUN so the sequencer can read them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_cause  <= '0;
      r_trap_code   <= TRAP_CODE_NONE;
      r_trap_result <= '0;
    end else if (w_trap_hit) begin
      r_trap_cause  <= w_cause;
      r_trap_code   <= w_code;
      r_trap_result <= i_result;
    end
  end

  assign o_sticky      = r_sticky;
  assign o_exc_count   = r_count;
  assign o_trap_req    = (r_state == TRAP);
  assign o_trap_cause  = r_trap_cause;
  assign o_trap_code   = r_trap_code;
  assign o_trap_result = r_trap_result;

endmodule : fpu_exception_collector
`default_nettype wire

// File: tb/tb_fpu_exception_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_exception_collector
// Purpose : Self-checking bench for fpu_exception_collector. Two instances
//           (16-bit and 4-bit counters) share the same stimulus. A
//           behavioural model predicts every output.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fpu_exception_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_result;
  logic [4:0]  i_exception;
  logic [4:0]  i_trap_en;
  logic        i_clear;
  logic        i_trap_ack;

  logic        ready_a, ready_b, req_a, req_b;
  logic [4:0]  sticky_a, sticky_b, cause_a, cause_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [2:0]  code_a, code_b;
  logic [31:0] res_a, res_b;

  always #5 clk = ~clk;

  fpu_exception_collector #(.BIT_WIDTH(32), .COUNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(ready_a),
    .i_result(i_result), .i_exception(i_exception), .i_trap_en(i_trap_en),
    .i_clear(i_clear), .i_trap_ack(i_trap_ack), .o_sticky(sticky_a),
    .o_exc_count(cnt_a), .o_trap_req(req_a), .o_trap_cause(cause_a),
    .o_trap_code(code_a), .o_trap_result(res_a)
  );

  fpu_exception_collector #(.BIT_WIDTH(32), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(ready_b),
    .i_result(i_result), .i_exception(i_exception), .i_trap_en(i_trap_en),
    .i_clear(i_clear), .i_trap_ack(i_trap_ack), .o_sticky(sticky_b),
    .o_exc_count(cnt_b), .o_trap_req(req_b), .o_trap_cause(cause_b),
    .o_trap_code(code_b), .o_trap_result(res_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_phase 0 = open for beats, 1 = trap pending,
  // 2 = one-cycle bubble after the acknowledge.
  logic [4:0]  m_sticky;
  int          m_cnt;
  int          m_phase;
  logic [4:0]  m_cause;
  logic [2:0]  m_code;
  logic [31:0] m_res;

  function automatic logic [2:0] ref_code(input logic [4:0] c);
    int order [5] = '{1, 2, 4, 3, 0};
    for (int i = 0; i < 5; i++)
      if (c[order[i]]) return 3'(order[i]);
    return 3'd7;
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
  endfunction

  function automatic logic [3:0] exp_cnt4();
    return (m_cnt > 15) ? 4'hF : 4'(m_cnt);
  endfunction

  task automatic model_reset();
    m_sticky = '0; m_cnt = 0; m_phase = 0;
    m_cause = '0; m_code = 3'd7; m_res = '0;
  endtask

  // Drives one cycle of inputs, waits for the edge, then updates the model.
  // The call returns 1ns after the edge.
  task automatic step(input logic v, input logic [4:0] e, input logic [31:0] r,
                      input logic [4:0] t, input logic cl, input logic ak);
    logic acc;
    i_valid = v; i_exception = e; i_result = r; i_trap_en = t;
    i_clear = cl; i_trap_ack = ak;
    acc = v && (m_phase == 0);
    @(posedge clk);
    if (cl) begin m_sticky = '0; m_cnt = 0; end
    if (acc) begin
      m_sticky = m_sticky | e;
      if (e != 0) m_cnt = m_cnt + 1;
    end
    if (m_phase == 0 && acc && (e & t) != 0) begin
      m_cause = e & t; m_code = ref_code(e & t); m_res = r; m_phase = 1;
    end else if (m_phase == 1 && ak) m_phase = 2;
    else if (m_phase == 2) m_phase = 0;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 0; i_exception = 0; i_result = 0; i_trap_en = 0;
    i_clear = 0; i_trap_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b want 0", ready_a, ready_b);
    end
    n_tests++;
    if (sticky_a !== 5'd0 || cnt_a !== 16'd0 || cnt_b !== 4'd0) begin
      n_fail++; $display("FAIL reset_status: sticky=%b cnt=%0d/%0d want 0", sticky_a, cnt_a, cnt_b);
    end
    n_tests++;
    if (req_a !== 1'b0 || cause_a !== 5'd0 || code_a !== 3'd7 || res_a !== 32'd0) begin
      n_fail++; $display("FAIL reset_trap: req=%b cause=%b code=%0d res=%h want 0/0/7/0", req_a, cause_a, code_a, res_a);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (ready_a !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", ready_a);
    end
  endtask

  task automatic test_no_trap();
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'b00001, 32'h1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'b01000, 32'h2, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (ready_a !== 1'b1 || req_a !== 1'b0) begin
      n_fail++; $display("FAIL no_trap_mid: ready=%b req=%b want 1/0", ready_a, req_a);
    end
    step(1'b1, 5'b00000, 32'h3, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (sticky_a !== 5'b01001 || cnt_a !== 16'd2) begin
      n_fail++; $display("FAIL no_trap_status: sticky=%b cnt=%0d want 01001/2", sticky_a, cnt_a);
    end
    n_tests++;
    if (req_a !== 1'b0 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL no_trap_flow: req=%b ready=%b want 0/1", req_a, ready_a);
    end
  endtask

  task automatic test_single_trap();
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'b10110, 32'h7FC00000, 5'b00110, 1'b0, 1'b0);
    n_tests++;
    if (req_a !== 1'b1 || cause_a !== 5'b00110 || code_a !== 3'd1 ||
        res_a !== 32'h7FC00000 || ready_a !== 1'b0) begin
      n_fail++; $display("FAIL single_trap_latch: req=%b cause=%b code=%0d res=%h ready=%b want 1/00110/1/7fc00000/0",
                         req_a, cause_a, code_a, res_a, ready_a);
    end
    idle();
    n_tests++;
    if (req_a !== 1'b1 || ready_a !== 1'b0) begin
      n_fail++; $display("FAIL single_trap_hold: req=%b ready=%b want 1/0", req_a, ready_a);
    end
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    n_tests++;
    if (req_a !== 1'b0 || ready_a !== 1'b0 || code_a !== 3'd1) begin
      n_fail++; $display("FAIL single_trap_bubble: req=%b ready=%b code=%0d want 0/0/1", req_a, ready_a, code_a);
    end
    idle();
    n_tests++;
    if (ready_a !== 1'b1 || res_a !== 32'h7FC00000) begin
      n_fail++; $display("FAIL single_trap_resume: ready=%b res=%h want 1/7fc00000", ready_a, res_a);
    end
  endtask

  task automatic test_clear_collision();
    logic [4:0] pats [7] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00001};
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, pats[i], 32'(i), 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (sticky_a !== 5'b11111 || cnt_a !== 16'd7) begin
      n_fail++; $display("FAIL clear_setup: sticky=%b cnt=%0d want 11111/7", sticky_a, cnt_a);
    end
    step(1'b1, 5'b00100, 32'h9, 5'd0, 1'b1, 1'b0);
    n_tests++;
    if (sticky_a !== 5'b00100 || cnt_a !== 16'd1 || cnt_b !== 4'd1) begin
      n_fail++; $display("FAIL clear_collision: sticky=%b cnt=%0d/%0d want 00100/1", sticky_a, cnt_a, cnt_b);
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (cnt_b !== 4'hF || cnt_a !== 16'd20) begin
      n_fail++; $display("FAIL saturation: cnt4=%0d cnt16=%0d want 15/20", cnt_b, cnt_a);
    end
  endtask

  task automatic test_stray_ack_backpressure();
    logic [4:0] s0;
    step(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    step(1'b0, 5'd0, 32'd0, 5'b11111, 1'b0, 1'b1);
    n_tests++;
    if (ready_a !== 1'b1 || req_a !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack: ready=%b req=%b want 1/0", ready_a, req_a);
    end
    step(1'b1, 5'b00001, 32'hABCD0001, 5'b00001, 1'b0, 1'b0);
    s0 = sticky_a;
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'b11110, 32'h55, 5'b11111, 1'b0, 1'b0);
    n_tests++;
    if (sticky_a !== s0 || sticky_a !== 5'b00001 || cause_a !== 5'b00001 ||
        code_a !== 3'd0 || req_a !== 1'b1) begin
      n_fail++; $display("FAIL backpressure: sticky=%b cause=%b code=%0d req=%b want 00001/00001/0/1",
                         sticky_a, cause_a, code_a, req_a);
    end
    step(1'b1, 5'b11110, 32'h55, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'b11110, 32'h55, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (sticky_a !== 5'b00001 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_bubble: sticky=%b ready=%b want 00001/1", sticky_a, ready_a);
    end
    step(1'b1, 5'b11110, 32'h55, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (sticky_a !== 5'b11111 || cnt_a !== 16'd2) begin
      n_fail++; $display("FAIL backpressure_accept: sticky=%b cnt=%0d want 11111/2", sticky_a, cnt_a);
    end
  endtask

  task automatic test_reset_mid_trap();
    step(1'b1, 5'b00100, 32'h12345678, 5'b00100, 1'b0, 1'b0);
    n_tests++;
    if (req_a !== 1'b1 || code_a !== 3'd2) begin
      n_fail++; $display("FAIL mid_trap_setup: req=%b code=%0d want 1/2", req_a, code_a);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (req_a !== 1'b0 || code_a !== 3'd7 || sticky_a !== 5'd0 ||
        ready_a !== 1'b0 || res_a !== 32'd0 || cnt_a !== 16'd0) begin
      n_fail++; $display("FAIL mid_trap_reset: req=%b code=%0d sticky=%b ready=%b res=%h cnt=%0d want 0/7/0/0/0/0",
                         req_a, code_a, sticky_a, ready_a, res_a, cnt_a);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    step(1'b1, 5'b00010, 32'h1, 5'd0, 1'b0, 1'b0);
    n_tests++;
    if (sticky_a !== 5'b00010 || ready_a !== 1'b1) begin
      n_fail++; $display("FAIL mid_trap_release: sticky=%b ready=%b want 00010/1", sticky_a, ready_a);
    end
  endtask

  task automatic test_random();
    logic        have;
    logic [4:0]  be;
    logic [31:0] br;
    logic [4:0]  t;
    logic        cl, ak;
    have = 1'b0; be = '0; br = '0;
    for (int n = 0; n < 400; n++) begin
      if (!have && $urandom_range(0, 2) != 0) begin
        have = 1'b1;
        be = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        br = $urandom;
      end
      t  = 5'($urandom) & 5'($urandom) & 5'($urandom);
      cl = ($urandom_range(0, 15) == 0);
      ak = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      n_tests++;
      if (ready_a !== (m_phase == 0) || ready_b !== (m_phase == 0)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b/%b want %b", n, ready_a, ready_b, m_phase == 0);
      end
      if (have && m_phase == 0) begin
        step(1'b1, be, br, t, cl, ak);
        have = 1'b0;
      end else begin
        step(have, be, br, t, cl, ak);
      end
      n_tests++;
      if (sticky_a !== m_sticky || sticky_b !== m_sticky || cnt_a !== exp_cnt16() || cnt_b !== exp_cnt4()) begin
        n_fail++; $display("FAIL rand_status[%0d]: sticky=%b cnt=%0d/%0d want %b/%0d/%0d",
                           n, sticky_a, cnt_a, cnt_b, m_sticky, exp_cnt16(), exp_cnt4());
      end
      n_tests++;
      if (req_a !== (m_phase == 1) || cause_a !== m_cause || code_a !== m_code || res_a !== m_res) begin
        n_fail++; $display("FAIL rand_trap[%0d]: req=%b cause=%b code=%0d res=%h want %b/%b/%0d/%h",
                           n, req_a, cause_a, code_a, res_a, m_phase == 1, m_cause, m_code, m_res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_trap();
    test_single_trap();
    test_clear_collision();
    test_saturation();
    test_stray_ack_backpressure();
    test_reset_mid_trap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fpu_exception_collector
`default_nettype wire
